// File: rtl/iir_biquad_scheduler.sv
// Shared biquad MAC scheduler: round-robin over CH sample streams,
// five single-multiplier taps, round/saturate, channel-tagged output.
module iir_biquad_scheduler #(
  parameter int CH        = 4,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 32,
  parameter int COEF_FRAC = 28,
  parameter int B0        = 53,
  parameter int B1        = 0,
  parameter int B2        = -53,
  parameter int A1        = -536870803,
  parameter int A2        = 268435348
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic [CH-1:0]          s_valid,
  input  logic [CH*DATA_W-1:0]   s_data,
  output logic [CH-1:0]          s_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic [$clog2(CH)-1:0]  m_chan,
  input  logic                   m_ready,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [COEF_W-1:0]      cfg_data,
  output logic                   cfg_ready,
  output logic                   busy
);
  localparam int CW = $clog2(CH);
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + 3;
  localparam logic signed [AW-1:0] HALF =
    {{(AW-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
  localparam logic signed [AW-1:0] YMAX =
    {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {
    S_IDLE, S_MAC, S_ROUND, S_OUT
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_rr;
  logic [CW-1:0]             r_grant;
  logic [2:0]                r_tap;
  logic signed [DATA_W-1:0]  r_x;
  logic signed [DATA_W-1:0]  r_x1 [CH];
  logic signed [DATA_W-1:0]  r_x2 [CH];
  logic signed [DATA_W-1:0]  r_y1 [CH];
  logic signed [DATA_W-1:0]  r_y2 [CH];
  logic signed [COEF_W-1:0]  r_b0, r_b1, r_b2, r_a1, r_a2;
  logic signed [AW-1:0]      r_acc;
  logic                      r_m_valid;
  logic [DATA_W-1:0]         r_m_data;
  logic [CW-1:0]             r_m_chan;
  logic                      r_busy;

  int                        w_idx;
  logic                      w_found;
  logic [CW-1:0]             w_grant;
  logic                      w_take;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_samp;
  logic                      w_sub;
  logic signed [PW-1:0]      w_prod;
  logic signed [AW-1:0]      w_term;
  logic signed [AW-1:0]      w_sum;
  logic signed [AW-1:0]      w_rnd;
  logic signed [DATA_W-1:0]  w_y;

  // first requester at or above rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < CH; k++) begin
      w_idx = (int'(r_rr) + k) % CH;
      if (!w_found && s_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = CW'(w_idx);
      end
    end
  end

  assign w_take = resetn && (r_state == S_IDLE) && w_found;

  always_comb begin
    s_ready = '0;
    if (w_take) s_ready[w_grant] = 1'b1;
  end

  always_comb begin
    w_coef = r_b0;
    w_samp = r_x;
    w_sub  = 1'b0;
    case (r_tap)
      3'd1: begin w_coef = r_b1; w_samp = r_x1[r_grant]; end
      3'd2: begin w_coef = r_b2; w_samp = r_x2[r_grant]; end
      3'd3: begin
        w_coef = r_a1; w_samp = r_y1[r_grant]; w_sub = 1'b1;
      end
      3'd4: begin
        w_coef = r_a2; w_samp = r_y2[r_grant]; w_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_prod = PW'(w_samp) * PW'(w_coef);
  assign w_term = AW'(w_prod);
  assign w_sum  = r_acc + HALF;
  assign w_rnd  = w_sum >>> COEF_FRAC;

  always_comb begin
    if (w_rnd > YMAX)      w_y = YMAX[DATA_W-1:0];
    else if (w_rnd < YMIN) w_y = YMIN[DATA_W-1:0];
    else                   w_y = w_rnd[DATA_W-1:0];
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_tap     <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_chan  <= '0;
      r_busy    <= 1'b0;
      r_b0      <= COEF_W'(B0);
      r_b1      <= COEF_W'(B1);
      r_b2      <= COEF_W'(B2);
      r_a1      <= COEF_W'(A1);
      r_a2      <= COEF_W'(A2);
      for (int i = 0; i < CH; i++) begin
        r_x1[i] <= '0;
        r_x2[i] <= '0;
        r_y1[i] <= '0;
        r_y2[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && cfg_we) begin
        case (cfg_addr)
          3'd0: r_b0 <= cfg_data;
          3'd1: r_b1 <= cfg_data;
          3'd2: r_b2 <= cfg_data;
          3'd3: r_a1 <= cfg_data;
          3'd4: r_a2 <= cfg_data;
          3'd5: begin
            for (int i = 0; i < CH; i++) begin
              r_x1[i] <= '0;
              r_x2[i] <= '0;
              r_y1[i] <= '0;
              r_y2[i] <= '0;
            end
          end
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_x     <= s_data[int'(w_grant)*DATA_W +: DATA_W];
            r_grant <= w_grant;
            r_acc   <= '0;
            r_tap   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sub ? r_acc - w_term : r_acc + w_term;
          r_tap <= r_tap + 3'd1;
          if (r_tap == 3'd4) r_state <= S_ROUND;
        end
        S_ROUND: begin
          // history commits here so a stalled output is never recomputed
          r_m_data         <= w_y;
          r_m_chan         <= r_grant;
          r_m_valid        <= 1'b1;
          r_x2[r_grant]    <= r_x1[r_grant];
          r_x1[r_grant]    <= r_x;
          r_y2[r_grant]    <= r_y1[r_grant];
          r_y1[r_grant]    <= w_y;
          r_rr <= (int'(r_grant) == CH - 1) ? '0 : r_grant + CW'(1);
          r_state          <= S_OUT;
        end
        S_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_chan    = r_m_chan;
  assign busy      = r_busy;
  assign cfg_ready = resetn && (r_state == S_IDLE);

endmodule

// File: tb/tb_iir_biquad_scheduler.sv
// Bench for iir_biquad_scheduler: directed scenarios plus random traffic
// against a direct-form biquad reference model.
module tb_iir_biquad_scheduler;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic            aclk = 1'b0;
  logic            resetn = 1'b0;
  logic [CH-1:0]   s_valid = '0;
  logic [CH*DW-1:0] s_data = '0;
  logic [CH-1:0]   s_ready;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [CW-1:0]   m_chan;
  logic            m_ready = 1'b1;
  logic            cfg_we = 1'b0;
  logic [2:0]      cfg_addr = '0;
  logic [31:0]     cfg_data = '0;
  logic            cfg_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  iir_biquad_scheduler #(.CH(CH)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_chan(m_chan),
    .m_ready(m_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .busy(busy)
  );

  always #5 aclk = ~aclk;

  longint mb [5];
  longint mx1 [CH], mx2 [CH], my1 [CH], my2 [CH];
  int     mrr;

  function automatic void model_clear();
    for (int i = 0; i < CH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    mb[0] = 53; mb[1] = 0; mb[2] = -53;
    mb[3] = -536870803; mb[4] = 268435348;
    mrr = 0;
    model_clear();
  endfunction

  function automatic void model_cfg(input int a, input logic [31:0] d);
    if (a < 5) mb[a] = longint'(signed'(d));
    else if (a == 5) model_clear();
  endfunction

  function automatic logic [15:0] model_step(input int ch,
                                             input logic [15:0] x);
    longint xv, acc, y;
    xv  = longint'(signed'(x));
    acc = mb[0]*xv + mb[1]*mx1[ch] + mb[2]*mx2[ch]
        - mb[3]*my1[ch] - mb[4]*my2[ch];
    y = (acc + (longint'(1) <<< 27)) >>> 28;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    mx2[ch] = mx1[ch]; mx1[ch] = xv;
    my2[ch] = my1[ch]; my1[ch] = y;
    mrr = (ch + 1) % CH;
    return 16'(y);
  endfunction

  task automatic cfg_write(input int a, input logic [31:0] d);
    int n = 0;
    @(negedge aclk);
    while (!cfg_ready && n < 50) begin @(negedge aclk); n++; end
    checks++;
    if (!cfg_ready) begin
      errors++;
      $display("FAIL cfg_wait cfg_ready=%0b need 1", cfg_ready);
    end
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = d;
    model_cfg(a, d);
    @(negedge aclk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] x,
                      output logic [15:0] d, output logic [CW-1:0] c,
                      output int lat);
    int n = 0;
    d = '0; c = '0; lat = -1;
    @(negedge aclk);
    s_data[ch*DW +: DW] = x;
    s_valid[ch] = 1'b1;
    #1;
    while (!s_ready[ch] && n < 50) begin @(negedge aclk); #1; n++; end
    if (!s_ready[ch]) begin
      checks++; errors++;
      $display("FAIL grant_wait ch=%0d s_ready=%b", ch, s_ready);
      s_valid[ch] = 1'b0;
      return;
    end
    @(posedge aclk);
    @(negedge aclk);
    s_valid[ch] = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin @(negedge aclk); lat++; end
    d = m_data; c = m_chan;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = '1; m_ready = 1'b1;
    s_data = {$urandom, $urandom};
    repeat (3) begin
      @(negedge aclk);
      checks++;
      if (s_ready !== '0 || m_valid !== 1'b0 || m_data !== '0 ||
          cfg_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs s_ready=%b m_valid=%b m_data=%h cfg_ready=%b busy=%b need all 0",
                 s_ready, m_valid, m_data, cfg_ready, busy);
      end
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant s_ready=%b need 0001", s_ready);
    end
    s_valid = '0;
    model_reset();
  endtask

  task automatic test_abort();
    bit seen = 0;
    @(negedge aclk);
    s_data[1*DW +: DW] = 16'h7000;
    s_valid[1] = 1'b1;
    @(posedge aclk);
    @(negedge aclk); s_valid = '0;
    @(negedge aclk); resetn = 1'b0;
    @(negedge aclk); resetn = 1'b1;
    repeat (12) begin
      @(negedge aclk);
      if (m_valid) seen = 1;
    end
    checks++;
    if (seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort seen_valid=%0b busy=%b need 0 0", seen, busy);
    end
    model_reset();
  endtask

  task automatic test_passthrough();
    logic [15:0] d; logic [CW-1:0] c; int lat; logic [15:0] e;
    cfg_write(0, 32'h1000_0000);
    for (int a = 1; a < 5; a++) cfg_write(a, 32'h0);
    send(2, 16'h4000, d, c, lat);
    e = model_step(2, 16'h4000);
    checks++;
    if (lat !== 7 || d !== e || d !== 16'h4000 || c !== 2'd2) begin
      errors++;
      $display("FAIL passthrough lat=%0d data=%h chan=%0d need 7 %h 2",
               lat, d, c, e);
    end
  endtask

  task automatic run_recursion(input string tag);
    logic [15:0] d; logic [CW-1:0] c; int lat; logic [15:0] e;
    logic [15:0] fixed [3];
    fixed[0] = 16'h4000; fixed[1] = 16'h2000; fixed[2] = 16'h1000;
    for (int i = 0; i < 3; i++) begin
      send(0, (i == 0) ? 16'h4000 : 16'h0, d, c, lat);
      e = model_step(0, (i == 0) ? 16'h4000 : 16'h0);
      checks++;
      if (d !== e || d !== fixed[i] || c !== 2'd0 || lat !== 7) begin
        errors++;
        $display("FAIL %s_ch0_%0d data=%h chan=%0d lat=%0d need %h 0 7",
                 tag, i, d, c, lat, fixed[i]);
      end
      if (i < 2) begin
        send(1, 16'h0, d, c, lat);
        e = model_step(1, 16'h0);
        checks++;
        if (d !== e || d !== 16'h0 || c !== 2'd1) begin
          errors++;
          $display("FAIL %s_ch1_%0d data=%h chan=%0d need 0000 1",
                   tag, i, d, c);
        end
      end
    end
  endtask

  task automatic test_recursion();
    cfg_write(0, 32'h1000_0000);
    cfg_write(3, 32'hF800_0000);
    run_recursion("recursion");
  endtask

  task automatic test_saturation_rounding();
    logic [15:0] d; logic [CW-1:0] c; int lat; logic [15:0] e;
    logic [31:0] cb [3];
    logic [15:0] xs [3];
    logic [15:0] want [3];
    cb[0] = 32'h2000_0000; xs[0] = 16'h7000; want[0] = 16'h7FFF;
    cb[1] = 32'h2000_0000; xs[1] = 16'h9000; want[1] = 16'h8000;
    cb[2] = 32'h0800_0000; xs[2] = 16'h0001; want[2] = 16'h0001;
    cfg_write(3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cfg_write(0, cb[i]);
      send(3, xs[i], d, c, lat);
      e = model_step(3, xs[i]);
      checks++;
      if (d !== e || d !== want[i] || c !== 2'd3) begin
        errors++;
        $display("FAIL satround_%0d data=%h chan=%0d need %h 3",
                 i, d, c, want[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_q [$];
    logic [CW-1:0] ch_q [$];
    logic [15:0] ed; logic [CW-1:0] ec;
    int last = -1, ng = 0, g;
    bit cfg_done = 0;
    cfg_write(0, 32'h1000_0000);
    cfg_write(3, 32'hF800_0000);
    @(negedge aclk);
    for (int i = 0; i < CH; i++) s_data[i*DW +: DW] = 16'($urandom);
    s_valid = '1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (s_ready != '0) begin
        g = 0;
        for (int k = 0; k < CH; k++) if (s_ready[k]) g = k;
        checks++;
        if (s_ready !== CH'(1 << mrr)) begin
          errors++;
          $display("FAIL rr_grant s_ready=%b need %b", s_ready,
                   CH'(1 << mrr));
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 8) begin
            errors++;
            $display("FAIL rr_gap gap=%0d need 8", cyc - last);
          end
        end
        last = cyc;
        exp_q.push_back(model_step(g, s_data[g*DW +: DW]));
        ch_q.push_back(CW'(g));
        ng++;
      end
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rr_extra data=%h chan=%0d need no output",
                   m_data, m_chan);
        end else begin
          ed = exp_q.pop_front(); ec = ch_q.pop_front();
          if (m_data !== ed || m_chan !== ec) begin
            errors++;
            $display("FAIL rr_out data=%h chan=%0d need %h %0d",
                     m_data, m_chan, ed, ec);
          end
        end
      end
      if (!cfg_done && last >= 0 && cyc == last + 2) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL cfg_in_mac cfg_ready=%b need 0", cfg_ready);
        end
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 32'h7FFF_FFFF;
        cfg_done = 1;
      end else begin
        cfg_we = 1'b0;
      end
      if (cyc >= 33 && busy && s_ready == '0) s_valid = '0;
      if (cyc >= 33 && !busy && exp_q.size() == 0) break;
      @(negedge aclk);
    end
    s_valid = '0; cfg_we = 1'b0;
    checks++;
    if (ng != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_count grants=%0d pending=%0d need 5 0",
               ng, exp_q.size());
    end
  endtask

  task automatic test_backpressure_clear();
    logic [15:0] d; logic [CW-1:0] c; int lat; logic [15:0] e;
    m_ready = 1'b0;
    send(0, 16'h1234, d, c, lat);
    e = model_step(0, 16'h1234);
    checks++;
    if (d !== e || c !== 2'd0 || lat !== 7) begin
      errors++;
      $display("FAIL bp_first data=%h chan=%0d lat=%0d need %h 0 7",
               d, c, lat, e);
    end
    s_valid = '1;
    repeat (10) begin
      @(negedge aclk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== d || m_chan !== c ||
          s_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold v=%b data=%h chan=%0d s_ready=%b need 1 %h %0d 0000",
                 m_valid, m_data, m_chan, s_ready, d, c);
      end
    end
    s_valid = '0;
    m_ready = 1'b1;
    @(negedge aclk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release m_valid=%b need 0", m_valid);
    end
    cfg_write(5, 32'h0);
    cfg_write(0, 32'h1000_0000);
    cfg_write(3, 32'hF800_0000);
    run_recursion("clear");
  endtask

  task automatic test_cfg_with_grant();
    logic [15:0] e; int n;
    int    ad [2];
    logic [31:0] dv [2];
    logic [15:0] xv [2];
    ad[0] = 0; dv[0] = 32'h2000_0000; xv[0] = 16'h2000;
    ad[1] = 5; dv[1] = 32'h0;         xv[1] = 16'h1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      s_data[2*DW +: DW] = xv[i];
      s_valid[2] = 1'b1;
      cfg_we = 1'b1; cfg_addr = 3'(ad[i]); cfg_data = dv[i];
      #1;
      checks++;
      if (s_ready !== 4'b0100 || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg_grant_%0d s_ready=%b cfg_ready=%b need 0100 1",
                 i, s_ready, cfg_ready);
      end
      model_cfg(ad[i], dv[i]);
      e = model_step(2, xv[i]);
      @(negedge aclk);
      s_valid = '0; cfg_we = 1'b0;
      n = 0;
      while (!m_valid && n < 40) begin @(negedge aclk); n++; end
      checks++;
      if (m_valid !== 1'b1 || m_data !== e || m_chan !== 2'd2) begin
        errors++;
        $display("FAIL cfg_grant_out_%0d v=%b data=%h chan=%0d need 1 %h 2",
                 i, m_valid, m_data, m_chan, e);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] d; logic [CW-1:0] c; int lat; logic [15:0] e;
    int ch; logic [15:0] x;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, 5),
                  32'($urandom_range(0, 1 << 30)) - 32'(1 << 29));
      ch = $urandom_range(0, CH - 1);
      x  = 16'($urandom);
      send(ch, x, d, c, lat);
      e = model_step(ch, x);
      checks++;
      if (d !== e || c !== CW'(ch) || lat !== 7) begin
        errors++;
        $display("FAIL random_%0d data=%h chan=%0d lat=%0d need %h %0d 7",
                 i, d, c, lat, e, ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_passthrough();
    test_recursion();
    test_saturation_rounding();
    test_round_robin();
    test_backpressure_clear();
    test_cfg_with_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_biquad_scheduler.md
# iir_biquad_scheduler

Time-multiplexed controller that shares one biquad multiply-accumulate datapath among `CH` independent ADC sample streams. It runs a round-robin arbiter over the per-channel input handshakes and holds per-channel filter state (x[n-1], x[n-2], y[n-1], y[n-2]). Each accepted sample is sequenced through five single-multiplier MAC cycles, then rounded, saturated and emitted with its channel tag. It sits between the AD9226 capture stage and the AXI-Stream packer, and replaces one biquad instance per channel.

## Interface

Parameters:
- `CH`, 4: number of channels, 2..8.
- `DATA_W`, 16: sample width, signed Q1.(DATA_W-1).
- `COEF_W`, 32: coefficient width, signed.
- `COEF_FRAC`, 28: coefficient fractional bits.
- `B0`, `B1`, `B2`, `A1`, `A2`, defaults 53, 0, -53, -536870803, 268435348: reset values of the coefficient registers.

Ports:
- Reset `resetn`, synchronous, active-low; clock `aclk`.
- `aclk`, in, 1: clock.
- `resetn`, in, 1: reset.
- `s_valid`, in, CH: per-channel sample valid.
- `s_data`, in, CH*DATA_W: per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W].
- `s_ready`, out, CH: per-channel accept; one-hot or zero.
- `m_valid`, out, 1: filtered sample valid.
- `m_data`, out, DATA_W: filtered sample.
- `m_chan`, out, clog2(CH): channel of `m_data`.
- `m_ready`, in, 1: downstream accept.
- `cfg_we`, in, 1: configuration write strobe.
- `cfg_addr`, in, 3: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2, 5=clear all channel state, 6..7 ignored.
- `cfg_data`, in, COEF_W: coefficient value.
- `cfg_ready`, out, 1: write accepted when `cfg_we & cfg_ready`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, MAC, ROUND, OUT.
- IDLE:
  - The grant is the first channel with `s_valid` high, searching upward from `rr_ptr` with wrap-around.
  - `s_ready[grant]=1`. This is combinational from the state and `s_valid`.
  - On the handshake: capture x and the grant, clear the accumulator, set tap=0, go to MAC.
- MAC: one product per cycle, accumulated into a signed accumulator of DATA_W+COEF_W+3 bits.
  - tap 0: +B0·x
  - tap 1: +B1·x1
  - tap 2: +B2·x2
  - tap 3: −A1·y1
  - tap 4: −A2·y2
  - After tap 4, go to ROUND.
- ROUND:
  - y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, saturated to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
  - Load y into `m_data` and the grant into `m_chan`.
  - Update the granted channel only: x2←x1, x1←x, y2←y1, y1←y (saturated y).
  - `rr_ptr` ← grant+1 mod CH. Go to OUT.
- OUT: `m_valid=1`. `m_data` and `m_chan` are held stable until `m_ready`. On `m_valid & m_ready`, go to IDLE.
- Configuration:
  - `cfg_ready` = (state==IDLE).
  - A write in the same cycle as a sample grant takes effect for that sample, because MAC starts on the next cycle.
  - Address 5 zeroes all channel state. If a grant occurs in the same cycle, the captured x is still used, and that channel's history reads as zero.
- Reset: state←IDLE, `rr_ptr`←0, all channel state←0, coefficients←parameter defaults.
  - `m_valid`, `m_data`, `m_chan`, `busy`, `s_ready` and `cfg_ready` are 0 during reset.
  - A reset asserted mid-operation aborts the sample and no output is produced.

## Timing

- Cycle 0: input handshake.
- Cycles 1–5: MAC taps 0–4.
- Cycle 6: ROUND.
- Cycle 7: `m_valid` rises.
- Input-to-output latency is 7 cycles.
- With `m_ready` held high, the next handshake is at cycle 8, giving a throughput of 1 sample per 8 cycles shared across all channels.
- `s_ready` is 0 outside IDLE. Ungranted channels keep `s_valid` and data asserted; no drop is permitted.
- Backpressure only extends OUT. Channel state is already committed at ROUND, so a held output is never recomputed.
- `busy` is registered and equals (state≠IDLE).

## Test plan

- Reset: hold `resetn=0` 3 cycles with `s_valid=4'hF` → `s_ready=0`, `m_valid=0`, `m_data=0`, `cfg_ready=0`. After release, the first grant is ch0.
- Passthrough: B0=0x10000000, B1=B2=A1=A2=0; ch2 x=0x4000 → `m_valid` exactly 7 cycles after the handshake, `m_data=0x4000`, `m_chan=2`.
- Recursion: B0=0x10000000, A1=0xF8000000 (−0.5); ch0 x=0x4000, 0, 0 → outputs 0x4000, 0x2000, 0x1000. Ch1 fed 0 in between outputs 0, which checks state isolation.
- Saturation: B0=0x20000000; x=0x7000 → 0x7FFF, x=0x9000 → 0x8000. Rounding: B0=0x08000000, x=0x0001 → 0x0001 (round half up).
- Round-robin: `s_valid=4'hF` held for 40 cycles → grants 0,1,2,3,0 with handshakes every 8 cycles. A cfg write during MAC sees `cfg_ready=0` and the coefficient is unchanged.
- Backpressure/clear: `m_ready=0` for 10 cycles in OUT → `m_data` and `m_chan` stable, all `s_ready=0`. Then `cfg_addr=5` in IDLE, and a repeat of the recursion test restarts from 0x4000.
